// File: rtl/spi_pkg.sv
// Shared definitions for the SPI shift register.
// Holds the FSM state encoding and the default frame width.
package spi_pkg;

   localparam int SPI_DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      DONE   = 2'd2
   } state_t;

endpackage

// File: rtl/spi_shift_register.sv
// SPI master shift register: serialises one frame onto mosi and
// assembles the word arriving on miso, timed by tx_edge/rx_edge.
module spi_shift_register
   import spi_pkg::*;
#(
   parameter int DATA_W = SPI_DATA_W
) (
   input  logic              PCLK,
   input  logic              PRESET,
   input  logic              send_data,
   input  logic [DATA_W-1:0] data_mosi,
   input  logic              lsbfe,
   input  logic              cpha,
   input  logic              ss,
   input  logic              tx_edge,
   input  logic              rx_edge,
   input  logic              miso,
   input  logic              receive_data,
   output logic              mosi,
   output logic [DATA_W-1:0] data_miso,
   output logic              rx_valid,
   output logic              busy
);

   localparam int CNT_W = $clog2(DATA_W + 1);
   localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DATA_W);

   function automatic logic [IDX_W-1:0] step_idx(
      input logic [IDX_W-1:0] idx,
      input logic             up
   );
      return up ? idx + 1'b1 : idx - 1'b1;
   endfunction

   state_t            state;
   state_t            state_nxt;
   logic [DATA_W-1:0] tx_reg;
   logic [DATA_W-1:0] rx_reg;
   logic [DATA_W-1:0] rx_merged;
   logic [CNT_W-1:0]  tx_cnt;
   logic [CNT_W-1:0]  rx_cnt;
   logic [IDX_W-1:0]  tx_idx;
   logic [IDX_W-1:0]  rx_idx;
   logic [IDX_W-1:0]  first_idx;
   logic              lsb_q;
   logic              armed;
   logic              tx_fire;
   logic              rx_fire;

   assign first_idx = lsbfe ? '0 : IDX_W'(DATA_W - 1);
   assign tx_fire   = (state == ACTIVE) && tx_edge && !ss && (tx_cnt < FULL);
   assign rx_fire   = (state == ACTIVE) && rx_edge && !ss && (rx_cnt < FULL);
   assign busy      = (state != IDLE);

   // Word as it stands after this cycle's sample, so a coincident
   // receive_data still sees the final bit.
   always_comb begin
      rx_merged = rx_reg;
      if (rx_fire) rx_merged[rx_idx] = miso;
   end

   always_comb begin
      state_nxt = state;
      if (send_data) begin
         state_nxt = ACTIVE;
      end else begin
         unique case (state)
            IDLE: state_nxt = IDLE;
            ACTIVE: begin
               if (receive_data)
                  state_nxt = IDLE;
               else if (tx_cnt == FULL && rx_cnt == FULL)
                  state_nxt = DONE;
            end
            DONE: if (receive_data) state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         mosi      <= 1'b0;
         data_miso <= '0;
         rx_valid  <= 1'b0;
         tx_reg    <= '0;
         rx_reg    <= '0;
         tx_cnt    <= '0;
         rx_cnt    <= '0;
         tx_idx    <= '0;
         rx_idx    <= '0;
         lsb_q     <= 1'b0;
         armed     <= 1'b0;
      end else begin
         // No word is reported until a frame has been loaded since reset.
         rx_valid <= receive_data && armed;
         if (receive_data) data_miso <= rx_merged;
         if (send_data) begin
            armed  <= 1'b1;
            tx_reg <= data_mosi;
            rx_reg <= '0;
            rx_cnt <= '0;
            rx_idx <= first_idx;
            lsb_q  <= lsbfe;
            if (cpha) begin
               tx_cnt <= '0;
               tx_idx <= first_idx;
            end else begin
               mosi   <= data_mosi[first_idx];
               tx_cnt <= CNT_W'(1);
               tx_idx <= step_idx(first_idx, lsbfe);
            end
         end else begin
            if (tx_fire) begin
               mosi   <= tx_reg[tx_idx];
               tx_cnt <= tx_cnt + 1'b1;
               tx_idx <= step_idx(tx_idx, lsb_q);
            end
            if (rx_fire) begin
               rx_reg <= rx_merged;
               rx_cnt <= rx_cnt + 1'b1;
               rx_idx <= step_idx(rx_idx, lsb_q);
            end
         end
      end
   end

endmodule
